// File: rtl/usart_cmd_decoder.sv
// Host command framer: SYNC, OPCODE, payload, XOR CHK -> atomic config update and arm/abort strobes.
// Define USART_CMD_ACK_EN to add the tx_data/tx_valid/tx_ready response channel.
module usart_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] DIV_RESET      = 16'd1,
  parameter logic [15:0] DEPTH_RESET    = 16'd1024
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        rx_error,
  output logic [15:0] cfg_div,
  output logic [7:0]  cfg_trig_mask,
  output logic [7:0]  cfg_trig_value,
  output logic [15:0] cfg_depth,
  output logic        arm,
  output logic        abort,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [1:0]  err_code
`ifdef USART_CMD_ACK_EN
  ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_DIV   = 8'h01;
  localparam logic [7:0] OP_TRIG  = 8'h02;
  localparam logic [7:0] OP_DEPTH = 8'h03;
  localparam logic [7:0] OP_ARM   = 8'h10;
  localparam logic [7:0] OP_ABORT = 8'h11;

  typedef enum logic [1:0] {IDLE, OPCODE, PAYLOAD, CHECK} state_t;

  state_t          state, state_nxt;
  logic [7:0]      op, chk;
  logic [1:0][7:0] shadow;
  logic            idx;
  logic [TW-1:0]   timer;

  logic            in_frame, tmo, byte_acc, op_valid, op_payload;
  logic            commit, fire_err;
  logic [1:0]      code_nxt;
  logic            arm_d, abort_d;

  assign in_frame   = (state != IDLE);
  assign tmo        = in_frame && (timer == TMO_MAX);
  // rx_error and timeout both terminate the frame and swallow any same-cycle byte
  assign byte_acc   = rx_ready && !(in_frame && (rx_error || tmo));
  assign op_valid   = (rx_data == OP_DIV) || (rx_data == OP_TRIG) || (rx_data == OP_DEPTH) ||
                      (rx_data == OP_ARM) || (rx_data == OP_ABORT);
  assign op_payload = (rx_data[7:4] == 4'h0);

  // state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state and frame events
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    fire_err  = 1'b0;
    code_nxt  = err_code;
    if (in_frame && rx_error) begin
      fire_err  = 1'b1;
      code_nxt  = 2'd3;
      state_nxt = IDLE;
    end else if (tmo) begin
      fire_err  = 1'b1;
      code_nxt  = 2'd2;
      state_nxt = IDLE;
    end else if (rx_ready) begin
      case (state)
        IDLE:    if (rx_data == SYNC_BYTE) state_nxt = OPCODE;
        OPCODE: begin
          if (op_valid) state_nxt = op_payload ? PAYLOAD : CHECK;
          else begin
            fire_err  = 1'b1;
            code_nxt  = 2'd0;
            state_nxt = IDLE;
          end
        end
        PAYLOAD: if (idx) state_nxt = CHECK;
        CHECK: begin
          if (rx_data == chk) commit = 1'b1;
          else begin
            fire_err = 1'b1;
            code_nxt = 2'd1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // output decode (registered below)
  always_comb begin
    arm_d   = commit && (op == OP_ARM);
    abort_d = commit && (op == OP_ABORT);
  end

  // frame datapath: opcode, shadow payload, running checksum, inter-byte timer
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      op     <= '0;
      chk    <= '0;
      shadow <= '0;
      idx    <= 1'b0;
      timer  <= '0;
    end else begin
      if (byte_acc && state == OPCODE) begin
        op  <= rx_data;
        chk <= rx_data;
        idx <= 1'b0;
      end
      if (byte_acc && state == PAYLOAD) begin
        shadow[idx] <= rx_data;
        chk         <= chk ^ rx_data;
        idx         <= 1'b1;
      end
      if (byte_acc || state_nxt == IDLE) timer <= '0;
      else                               timer <= timer + TW'(1);
    end
  end

  // config and strobes; whole register written from shadow on the commit edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cfg_div        <= DIV_RESET;
      cfg_trig_mask  <= 8'h00;
      cfg_trig_value <= 8'h00;
      cfg_depth      <= DEPTH_RESET;
      arm            <= 1'b0;
      abort          <= 1'b0;
      cmd_ok         <= 1'b0;
      cmd_err        <= 1'b0;
      err_code       <= 2'd0;
    end else begin
      arm     <= arm_d;
      abort   <= abort_d;
      cmd_ok  <= commit;
      cmd_err <= fire_err;
      if (fire_err) err_code <= code_nxt;
      if (commit) begin
        case (op)
          OP_DIV:   cfg_div <= {shadow[1], shadow[0]};
          OP_TRIG: begin
            cfg_trig_mask  <= shadow[0];
            cfg_trig_value <= shadow[1];
          end
          OP_DEPTH: cfg_depth <= {shadow[1], shadow[0]};
          default: ;
        endcase
      end
    end
  end

`ifdef USART_CMD_ACK_EN
  // response byte: opcode on accept, E0|code on reject; latest response wins
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (commit) begin
      tx_data  <= op;
      tx_valid <= 1'b1;
    end else if (fire_err) begin
      tx_data  <= {6'b111000, code_nxt};
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_usart_cmd_decoder.sv
// Directed self-checking bench for usart_cmd_decoder (short timeout for simulation speed).
module tb_usart_cmd_decoder;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  rx_data;
  logic        rx_ready, rx_error;
  logic [15:0] cfg_div, cfg_depth;
  logic [7:0]  cfg_trig_mask, cfg_trig_value;
  logic        arm, abort, cmd_ok, cmd_err;
  logic [1:0]  err_code;
`ifdef USART_CMD_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nreset(nreset),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .cfg_div(cfg_div), .cfg_trig_mask(cfg_trig_mask), .cfg_trig_value(cfg_trig_value),
    .cfg_depth(cfg_depth), .arm(arm), .abort(abort),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code)
`ifdef USART_CMD_ACK_EN
    , .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // byte strobe for the next rising edge; consecutive calls are back-to-back
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    rx_ready = 1'b0;
    rx_error = 1'b0;
  endtask

  initial begin
    int k;
    nreset = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0;
`ifdef USART_CMD_ACK_EN
    tx_ready = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_div", cfg_div, 16'd1);
    check("rst_depth", cfg_depth, 16'd1024);
    check("rst_mask", cfg_trig_mask, 8'h00);
    check("rst_value", cfg_trig_value, 8'h00);
    check("rst_strobes", {arm, abort, cmd_ok, cmd_err}, 4'b0000);
    check("rst_code", err_code, 2'd0);
    nreset = 1'b1;
    gap();

    // SET_DIV 0x1234, CHK = 01^34^12 = 27
    put(8'hA5); put(8'h01); put(8'h34); put(8'h12); put(8'h27);
    check("div_not_early", cfg_div, 16'd1);
    gap();
    check("div_value", cfg_div, 16'h1234);
    check("div_ok", {cmd_ok, cmd_err}, 2'b10);
    check("div_others", {cfg_depth, cfg_trig_mask, cfg_trig_value}, {16'd1024, 8'h00, 8'h00});
    gap();
    check("div_ok_1cyc", cmd_ok, 1'b0);

    // SET_TRIG F0/0F (CHK = 02^F0^0F = FD) back-to-back with ARM
    put(8'hA5); put(8'h02); put(8'hF0); put(8'h0F); put(8'hFD);
    put(8'hA5);
    check("trig_ok", cmd_ok, 1'b1);
    check("trig_regs", {cfg_trig_mask, cfg_trig_value}, 16'hF00F);
    put(8'h10);
    check("trig_ok_1cyc", cmd_ok, 1'b0);
    put(8'h10);
    gap();
    check("arm_pulse", {arm, abort, cmd_ok}, 3'b101);
    gap();
    check("arm_1cyc", {arm, cmd_ok}, 2'b00);

    // SET_DEPTH with bad CHK, then bad opcode
    put(8'hA5); put(8'h03); put(8'h00); put(8'h08); put(8'h00);
    gap();
    check("chk_err", {cmd_ok, cmd_err}, 2'b01);
    check("chk_code", err_code, 2'd1);
    check("chk_depth_kept", cfg_depth, 16'd1024);
    put(8'hA5); put(8'h77);
    gap();
    check("op_err", cmd_err, 1'b1);
    check("op_code", err_code, 2'd0);

    // timeout after partial frame
    put(8'hA5); put(8'h01); put(8'h34);
    gap();
    k = 1;
    while (k <= TMO + 10) begin
      @(negedge clk);
      if (cmd_err) break;
      k++;
    end
    check("tmo_cycles", k, TMO);
    check("tmo_code", err_code, 2'd2);
    // SET_DIV 0xABCD, CHK = 01^CD^AB = 67
    put(8'hA5); put(8'h01); put(8'hCD); put(8'hAB); put(8'h67);
    gap();
    check("tmo_recover_div", cfg_div, 16'hABCD);
    check("tmo_recover_ok", cmd_ok, 1'b1);
    check("code_holds", err_code, 2'd2);

    // ABORT
    put(8'hA5); put(8'h11); put(8'h11);
    gap();
    check("abort_pulse", {arm, abort, cmd_ok}, 3'b011);

    // rx_error in IDLE is ignored
    @(negedge clk); rx_error = 1'b1;
    gap();
    check("idle_rxerr", cmd_err, 1'b0);

    // rx_error with a same-cycle byte drops the byte
    put(8'hA5); put(8'h01); put(8'h55); rx_error = 1'b1;
    gap();
    check("rxerr_err", cmd_err, 1'b1);
    check("rxerr_code", err_code, 2'd3);
    check("rxerr_div_kept", cfg_div, 16'hABCD);
`ifdef USART_CMD_ACK_EN
    check("ack_data", tx_data, 8'hE3);
    repeat (3) @(negedge clk);
    check("ack_hold", tx_valid, 1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("ack_clear", tx_valid, 1'b0);
`endif
    // SET_TRIG AA/55 (CHK = 02^AA^55 = FD) proves the FSM returned to IDLE
    put(8'hA5); put(8'h02); put(8'hAA); put(8'h55); put(8'hFD);
    gap();
    check("post_rxerr_trig", {cfg_trig_mask, cfg_trig_value, cmd_ok}, {8'hAA, 8'h55, 1'b1});

    // reset mid-frame discards the partial frame
    put(8'hA5); put(8'h03); put(8'h00);
    gap();
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    put(8'h20); put(8'h23);
    gap();
    check("rst_midframe", {cfg_depth, cmd_ok, cmd_err}, {16'd1024, 2'b00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
